// File: rtl/seq_alu_exec_if.sv
// rtl/seq_alu_exec_if.sv - request/result bundle between EX-stage control and seq_alu_exec
interface seq_alu_exec_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [3:0]       ALUCtrl_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             done_o;
    logic             illegal_o;

    modport master (
        output valid_i, ALUCtrl_i, src1_i, src2_i,
        input  ready_o, result_o, zero_o, done_o, illegal_o
    );

    modport slave (
        input  valid_i, ALUCtrl_i, src1_i, src2_i,
        output ready_o, result_o, zero_o, done_o, illegal_o
    );
endinterface

// File: rtl/seq_alu_exec.sv
// rtl/seq_alu_exec.sv - EX-stage ALU: single-cycle logic/arith ops plus iterative shift-add MUL
module seq_alu_exec #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic           clk_i,
    input logic           rst_i,
    seq_alu_exec_if.slave bus
);
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] alu_res;
    logic             alu_illegal;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        alu_res     = '0;
        alu_illegal = 1'b0;
        unique case (bus.ALUCtrl_i)
            OP_AND:  alu_res = bus.src1_i & bus.src2_i;
            OP_OR:   alu_res = bus.src1_i | bus.src2_i;
            OP_NOR:  alu_res = ~(bus.src1_i | bus.src2_i);
            OP_ADD:  alu_res = bus.src1_i + bus.src2_i;
            OP_SUB:  alu_res = bus.src1_i - bus.src2_i;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
            default: alu_illegal = 1'b1;
        endcase
    end

    // One shift-add step; the last step's sum is the product, published directly.
    always_comb begin
        acc_next = mplier[0] ? (acc + mcand) : acc;
        cnt_next = cnt + 1'b1;
    end

    assign bus.ready_o = (state == S_IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= S_IDLE;
            mcand         <= '0;
            mplier        <= '0;
            acc           <= '0;
            cnt           <= '0;
            bus.result_o  <= '0;
            bus.zero_o    <= 1'b1;
            bus.done_o    <= 1'b0;
            bus.illegal_o <= 1'b0;
        end else begin
            bus.done_o    <= 1'b0;
            bus.illegal_o <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.valid_i) begin
                        if (bus.ALUCtrl_i == OP_MUL) begin
                            mcand  <= bus.src1_i;
                            mplier <= bus.src2_i;
                            acc    <= '0;
                            cnt    <= '0;
                            state  <= S_MUL;
                        end else begin
                            bus.result_o  <= alu_res;
                            bus.zero_o    <= (alu_res == '0);
                            bus.illegal_o <= alu_illegal;
                            bus.done_o    <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt_next;
                    if (cnt_next == LAST_CNT) begin
                        bus.result_o <= acc_next;
                        bus.zero_o   <= (acc_next == '0);
                        bus.done_o   <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu_exec.sv
// tb/tb_seq_alu_exec.sv - self-checking bench for seq_alu_exec against an arithmetic reference model
module tb_seq_alu_exec;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seq_alu_exec_if #(.WIDTH(W)) bus ();

    seq_alu_exec #(.WIDTH(W), .CNT_W(6)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Returns {illegal, result}
    function automatic logic [W:0] model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         ill;
        r   = '0;
        ill = 1'b0;
        case (c)
            4'h0:    r = a & b;
            4'h1:    r = a | b;
            4'hC:    r = ~(a | b);
            4'h2:    r = a + b;
            4'h6:    r = a - b;
            4'h7:    r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'h8:    r = a * b;
            default: ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    // Called and returns at a falling edge; consecutive calls form a back-to-back stream.
    task automatic run_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke_busy);
        logic [W:0] m;
        int         busy;
        m = model(c, a, b);
        check("ready_before_req", W'(bus.ready_o), 1);
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = c;
        bus.src1_i    = a;
        bus.src2_i    = b;
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        bus.src1_i  = $urandom;
        bus.src2_i  = $urandom;
        if (c == 4'h8) begin
            busy = 0;
            while (bus.ready_o === 1'b0 && busy < 100) begin
                check("done_while_busy", W'(bus.done_o), 0);
                busy++;
                if (poke_busy && busy < 20) begin
                    bus.valid_i   = 1'b1;
                    bus.ALUCtrl_i = 4'h2;
                end else begin
                    bus.valid_i = 1'b0;
                end
                @(negedge clk);
            end
            bus.valid_i = 1'b0;
            check("mul_busy_cycles", W'(busy), W);
        end
        check("done", W'(bus.done_o), 1);
        check("result", bus.result_o, m[W-1:0]);
        check("zero", W'(bus.zero_o), W'(m[W-1:0] == '0));
        check("illegal", W'(bus.illegal_o), W'(m[W]));
    endtask

    task automatic idle_check(input logic [W-1:0] held);
        @(negedge clk);
        check("idle_no_done", W'(bus.done_o), 0);
        check("idle_no_illegal", W'(bus.illegal_o), 0);
        check("idle_result_held", bus.result_o, held);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]   codes [10];
        logic [3:0]   c;
        logic [W-1:0] a;
        logic [W-1:0] b;
        codes = '{4'h0, 4'h1, 4'hC, 4'h2, 4'h6, 4'h7, 4'h8, 4'h3, 4'h9, 4'hF};

        bus.valid_i   = 1'b0;
        bus.ALUCtrl_i = 4'h0;
        bus.src1_i    = '0;
        bus.src2_i    = '0;

        @(negedge clk);
        @(negedge clk);
        check("rst_ready", W'(bus.ready_o), 1);
        check("rst_result", bus.result_o, 0);
        check("rst_zero", W'(bus.zero_o), 1);
        check("rst_done", W'(bus.done_o), 0);
        check("rst_illegal", W'(bus.illegal_o), 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(4'h2, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op(4'h6, 32'd5, 32'd5, 0);
        run_op(4'h7, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'h7, 32'd1, 32'hFFFF_FFFF, 0);
        run_op(4'h7, 32'd7, 32'd7, 0);
        run_op(4'h2, 32'h10, 32'h20, 0);

        // Asynchronous reset in the middle of a done cycle
        #2 rst = 1'b1;
        #1;
        check("async_rst_result", bus.result_o, 0);
        check("async_rst_zero", W'(bus.zero_o), 1);
        check("async_rst_done", W'(bus.done_o), 0);
        check("async_rst_ready", W'(bus.ready_o), 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(4'h8, 32'h0000_1234, 32'h0000_0010, 1);
        idle_check(32'h0001_2340);
        run_op(4'h8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        idle_check(32'h0000_0001);

        run_op(4'h0, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        run_op(4'h1, 32'hF0F0_F0F0, 32'hFF00_FF00, 0);
        run_op(4'hC, 32'h0, 32'h0, 0);
        run_op(4'h5, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        idle_check(32'h0);

        // Reset after ten MUL iterations: no completion may follow
        bus.valid_i   = 1'b1;
        bus.ALUCtrl_i = 4'h8;
        bus.src1_i    = 32'h0000_0003;
        bus.src2_i    = 32'h0000_0005;
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midmul_rst_ready", W'(bus.ready_o), 1);
        check("midmul_rst_result", bus.result_o, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("midmul_no_done", W'(bus.done_o), 0);
        end
        run_op(4'h2, 32'd2, 32'd3, 0);

        for (int i = 0; i < 300; i++) begin
            c = codes[$urandom_range(0, 9)];
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = '0;
            run_op(c, a, b, 0);
            if ($urandom_range(0, 4) == 0) idle_check(model(c, a, b) & {1'b0, {W{1'b1}}});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
